// File: rtl/sm_run_ctrl.sv
// -----------------------------------------------------------------------------
// sm_run_ctrl -- run-control sequencer for the schoolMIPS core.
//
// Turns the system clock into a one-cycle CPU advance strobe (cpuEn) at a
// divide-selectable rate. Supports free run / halt, a debounced single-step
// push-button, and an optional PC breakpoint. The core advances one
// instruction per cpuEn pulse.
//
// Optional feature macro: SM_RUN_CTRL_BREAKPOINT_EN
//   defined   : PC breakpoint compare, resume-skip flag and BREAK state exist.
//   undefined : bpEnable/bpAddr/pc are ignored, BREAK is unreachable.
//
// Parameters
//   SHIFT      base divider exponent; tick period = 2^(SHIFT+devide) cycles
//   CNT_W      tick counter width (>= SHIFT+16)
//   DEB_CYCLES consecutive samples stepBtn must hold a new level
//   DEB_W      debounce counter width
//
// Ports
//   clkIn      in   1   system clock
//   rst_n      in   1   asynchronous reset, active low
//   devide     in   4   rate select (already synchronised)
//   runReq     in   1   1 = free run, 0 = halt (already synchronised)
//   stepBtn    in   1   raw single-step push-button, asynchronous
//   bpEnable   in   1   breakpoint enable
//   bpAddr     in   32  breakpoint PC
//   pc         in   32  current CPU PC
//   cpuEn      out  1   one-cycle advance strobe
//   state      out  2   00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   instrCount out  16  number of cpuEn pulses, wraps modulo 2^16
// -----------------------------------------------------------------------------
module sm_run_ctrl #(
  parameter int SHIFT      = 16,
  parameter int CNT_W      = 32,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic [3:0]  devide,
  input  logic        runReq,
  input  logic        stepBtn,
  input  logic        bpEnable,
  input  logic [31:0] bpAddr,
  input  logic [31:0] pc,
  output logic        cpuEn,
  output logic [1:0]  state,
  output logic [15:0] instrCount
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------------
  // Tick generator. The counter runs in every state. Using >= against the
  // limit means a rate increase (smaller devide) mid-count produces a tick on
  // the very next cycle instead of wrapping through the full counter range.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cntr_reg;
  logic [CNT_W-1:0] limit;
  logic             tick;

  assign limit = (CNT_W'(1) << (SHIFT + int'(devide))) - CNT_W'(1);
  assign tick  = (cntr_reg >= limit);

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cntr_reg <= '0;
    end else if (tick) begin
      cntr_reg <= '0;
    end else begin
      cntr_reg <= cntr_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Step button: two-flop synchroniser followed by a consecutive-sample
  // debouncer. Any sample equal to the current filtered level restarts the
  // count, so only an unbroken run of DEB_CYCLES new-level samples is accepted.
  // ---------------------------------------------------------------------------
  logic             sync1_reg, sync2_reg;
  logic             deb_level_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             deb_accept;
  logic             step_pulse_reg;

  assign deb_accept = (sync2_reg != deb_level_reg) &&
                      (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1));

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      deb_level_reg  <= 1'b0;
      deb_cnt_reg    <= '0;
      step_pulse_reg <= 1'b0;
    end else begin
      sync1_reg      <= stepBtn;
      sync2_reg      <= sync1_reg;
      // One-cycle pulse only on an accepted 0->1 change of the filtered level.
      step_pulse_reg <= deb_accept & sync2_reg;
      if (sync2_reg == deb_level_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_accept) begin
        deb_level_reg <= sync2_reg;
        deb_cnt_reg   <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Breakpoint compare (optional).
  // ---------------------------------------------------------------------------
  logic bp_hit;
  logic en_next;

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  // bp_skip_reg lets a resume execute the instruction sitting at the
  // breakpoint once; it is armed on entry to RUN and dropped after the first
  // strobe issued in RUN.
  logic bp_skip_reg;

  assign bp_hit = bpEnable && (pc == bpAddr) && !bp_skip_reg;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      bp_skip_reg <= 1'b0;
    end else if ((state_reg != S_RUN) && (state_next == S_RUN)) begin
      bp_skip_reg <= 1'b1;
    end else if ((state_reg == S_RUN) && en_next) begin
      bp_skip_reg <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{bpEnable, bpAddr, pc};
  assign bp_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    en_next    = 1'b0;
    case (state_reg)
      S_HALT: begin
        // runReq has priority; a simultaneous step pulse is dropped.
        if (runReq) begin
          state_next = S_RUN;
        end else if (step_pulse_reg) begin
          state_next = S_STEP;
        end
      end
      S_RUN: begin
        // Dropping runReq wins over a tick in the same cycle.
        if (!runReq) begin
          state_next = S_HALT;
        end else if (tick) begin
          if (bp_hit) begin
            state_next = S_BREAK;
          end else begin
            en_next = 1'b1;
          end
        end
      end
      S_STEP: begin
        // Further step pulses and runReq are ignored until the step completes.
        if (tick) begin
          en_next    = 1'b1;
          state_next = S_HALT;
        end
      end
      S_BREAK: begin
        if (!runReq) begin
          state_next = S_HALT;
        end else if (step_pulse_reg) begin
          state_next = S_STEP;
        end
      end
      default: begin
        state_next = S_HALT;
      end
    endcase
  end

  logic        cpu_en_reg;
  logic [15:0] count_reg;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_HALT;
      cpu_en_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cpu_en_reg <= en_next;
      // Count moves on the same edge that raises cpuEn.
      if (en_next) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign cpuEn      = cpu_en_reg;
  assign state      = state_reg;
  assign instrCount = count_reg;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm_run_ctrl -- self-checking bench for sm_run_ctrl.
// Main instance: SHIFT=2, DEB_CYCLES=4 (tick every 4 cycles at devide=0).
// Second instance: SHIFT=0 (tick every cycle) used for the 16-bit count wrap.
// -----------------------------------------------------------------------------
module tb_sm_run_ctrl;

  localparam int SHIFT      = 2;
  localparam int CNT_W      = 32;
  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 16;

  logic        clkIn = 1'b0;
  logic        rst_n;
  logic [3:0]  devide;
  logic        runReq;
  logic        stepBtn;
  logic        bpEnable;
  logic [31:0] bpAddr;
  logic [31:0] pc;
  logic        cpuEn;
  logic [1:0]  state;
  logic [15:0] instrCount;

  logic        w_rst_n;
  logic        w_runReq;
  logic        w_cpuEn;
  logic [1:0]  w_state;
  logic [15:0] w_count;

  always #5 clkIn = ~clkIn;

  sm_run_ctrl #(
    .SHIFT(SHIFT), .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)
  ) dut (
    .clkIn(clkIn), .rst_n(rst_n), .devide(devide), .runReq(runReq),
    .stepBtn(stepBtn), .bpEnable(bpEnable), .bpAddr(bpAddr), .pc(pc),
    .cpuEn(cpuEn), .state(state), .instrCount(instrCount)
  );

  sm_run_ctrl #(
    .SHIFT(0), .CNT_W(32), .DEB_CYCLES(4), .DEB_W(16)
  ) dut_wrap (
    .clkIn(clkIn), .rst_n(w_rst_n), .devide(4'd0), .runReq(w_runReq),
    .stepBtn(1'b0), .bpEnable(1'b0), .bpAddr(32'd0), .pc(32'd0),
    .cpuEn(w_cpuEn), .state(w_state), .instrCount(w_count)
  );

  int checks = 0;
  int errors = 0;

  // Monitor state shared by the cycle helper.
  int          pulse_cnt;
  int          double_cnt;
  bit          saw_step;
  bit          saw_break;
  logic        prev_en;
  logic [31:0] last_pc;

  typedef struct {
    logic        run;
    logic        exp_en;
    logic [1:0]  exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    runReq   = 1'b0;
    stepBtn  = 1'b0;
    bpEnable = 1'b0;
    bpAddr   = 32'd0;
    devide   = 4'd0;
    pc       = 32'd0;
    repeat (2) @(posedge clkIn);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_mon();
    pulse_cnt  = 0;
    double_cnt = 0;
    saw_step   = 1'b0;
    saw_break  = 1'b0;
    prev_en    = 1'b0;
  endtask

  // One clock; models the CPU PC advancing by 4 on every strobe.
  task automatic cyc();
    @(posedge clkIn);
    #1;
    if (cpuEn) begin
      pulse_cnt++;
      if (prev_en) double_cnt++;
      last_pc = pc;
      pc      = pc + 32'd4;
    end
    if (state == 2'b10) saw_step = 1'b1;
    if (state == 2'b11) saw_break = 1'b1;
    prev_en = cpuEn;
  endtask

  // Cycles until the next strobe is observed, or -1 if none within budget.
  task automatic wait_pulse(input int budget, output int n);
    bit found;
    found = 1'b0;
    n     = -1;
    for (int i = 1; i <= budget && !found; i++) begin
      cyc();
      if (cpuEn) begin
        n     = i;
        found = 1'b1;
      end
    end
  endtask

  initial begin
    int n;

    w_rst_n  = 1'b0;
    w_runReq = 1'b0;
    last_pc  = 32'd0;
    clear_mon();

    // Table: run, drop runReq mid-period, drop runReq exactly on a tick.
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 2'b01, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 16'd1};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 16'd1};
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 16'd2};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 16'd2};
    vecs[10] = '{1'b1, 1'b0, 2'b01, 16'd2};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 16'd3};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 16'd3};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 16'd3};
    vecs[14] = '{1'b0, 1'b0, 2'b00, 16'd3};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 16'd3};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 16'd3};
    vecs[17] = '{1'b1, 1'b0, 2'b01, 16'd3};
    vecs[18] = '{1'b1, 1'b0, 2'b01, 16'd3};
    vecs[19] = '{1'b0, 1'b0, 2'b00, 16'd3};
    vecs[20] = '{1'b0, 1'b0, 2'b00, 16'd3};

    // Reset state
    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_cpuEn", 32'(cpuEn), 32'd0);
    check("reset_count", 32'(instrCount), 32'd0);
    $display("reset: state=%0d cpuEn=%0d count=%0d", state, cpuEn, instrCount);

    for (int i = 0; i < 21; i++) begin
      runReq = vecs[i].run;
      @(posedge clkIn);
      #1;
      $display("vec %0d: run=%0d cpuEn=%0d state=%0d count=%0d",
               i, vecs[i].run, cpuEn, state, instrCount);
      check($sformatf("vec%0d_cpuEn", i), 32'(cpuEn), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_count", i), 32'(instrCount), 32'(vecs[i].exp_cnt));
    end

    // Free run for 40 cycles, then asynchronous reset while cpuEn is high.
    do_reset();
    runReq = 1'b1;
    clear_mon();
    repeat (40) cyc();
    $display("run40: pulses=%0d count=%0d state=%0d", pulse_cnt, instrCount, state);
    check("run40_pulses", 32'(pulse_cnt), 32'd10);
    check("run40_double", 32'(double_cnt), 32'd0);
    check("run40_count", 32'(instrCount), 32'd10);
    check("run40_state", 32'(state), 32'd1);
    check("pre_reset_cpuEn", 32'(cpuEn), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: cpuEn=%0d state=%0d count=%0d", cpuEn, state, instrCount);
    check("async_rst_cpuEn", 32'(cpuEn), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_count", 32'(instrCount), 32'd0);
    @(posedge clkIn);
    #1;
    rst_n = 1'b1;

    // Divider change from HALT and a mid-count rate increase.
    do_reset();
    runReq = 1'b1;
    clear_mon();
    wait_pulse(20, n);
    check("div0_first_seen", 32'(n > 0), 32'd1);
    wait_pulse(20, n);
    check("div0_spacing", 32'(n), 32'd4);
    runReq = 1'b0;
    cyc();
    devide = 4'd2;
    repeat (3) cyc();
    runReq = 1'b1;
    wait_pulse(40, n);
    check("div2_first_seen", 32'(n > 0), 32'd1);
    wait_pulse(40, n);
    check("div2_spacing_a", 32'(n), 32'd16);
    wait_pulse(40, n);
    check("div2_spacing_b", 32'(n), 32'd16);
    repeat (8) cyc();
    devide = 4'd0;
    wait_pulse(40, n);
    check("div_dec_immediate", 32'(n), 32'd1);
    wait_pulse(40, n);
    check("div_dec_spacing", 32'(n), 32'd4);
    check("div_double", 32'(double_cnt), 32'd0);
    $display("divider: pulses=%0d count=%0d", pulse_cnt, instrCount);

    // Debounced single-step with a bouncy press, a too-short press, a clean press.
    do_reset();
    clear_mon();
    stepBtn = 1'b1; cyc();
    stepBtn = 1'b0; cyc();
    stepBtn = 1'b1; cyc();
    repeat (10) cyc();
    stepBtn = 1'b0;
    repeat (17) cyc();
    $display("step1: pulses=%0d saw_step=%0d state=%0d count=%0d",
             pulse_cnt, saw_step, state, instrCount);
    check("step1_pulses", 32'(pulse_cnt), 32'd1);
    check("step1_saw_step", 32'(saw_step), 32'd1);
    check("step1_state", 32'(state), 32'd0);
    check("step1_count", 32'(instrCount), 32'd1);

    clear_mon();
    stepBtn = 1'b1;
    repeat (3) cyc();
    stepBtn = 1'b0;
    repeat (12) cyc();
    $display("short press: pulses=%0d saw_step=%0d", pulse_cnt, saw_step);
    check("short_pulses", 32'(pulse_cnt), 32'd0);
    check("short_saw_step", 32'(saw_step), 32'd0);

    clear_mon();
    stepBtn = 1'b1;
    repeat (10) cyc();
    stepBtn = 1'b0;
    repeat (17) cyc();
    $display("step2: pulses=%0d state=%0d count=%0d", pulse_cnt, state, instrCount);
    check("step2_pulses", 32'(pulse_cnt), 32'd1);
    check("step2_state", 32'(state), 32'd0);
    check("step2_count", 32'(instrCount), 32'd2);

    // runReq and the step pulse arrive in the same HALT cycle.
    do_reset();
    clear_mon();
    stepBtn = 1'b1;
    repeat (6) cyc();
    runReq = 1'b1;
    cyc();
    check("simul_state", 32'(state), 32'd1);
    repeat (6) cyc();
    stepBtn = 1'b0;
    $display("simultaneous: state=%0d saw_step=%0d", state, saw_step);
    check("simul_no_step", 32'(saw_step), 32'd0);

    // Breakpoint at PC 0x0C.
    do_reset();
    bpAddr   = 32'h0000_000C;
    bpEnable = 1'b1;
    pc       = 32'd0;
    runReq   = 1'b1;
    clear_mon();
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    for (int i = 0; i < 60 && state != 2'b11; i++) cyc();
    $display("breakpoint: state=%0d pc=0x%0h pulses=%0d", state, pc, pulse_cnt);
    check("bp_state", 32'(state), 32'd3);
    check("bp_pc", pc, 32'h0000_000C);
    check("bp_pulses", 32'(pulse_cnt), 32'd3);
    check("bp_no_en", 32'(cpuEn), 32'd0);
    clear_mon();
    repeat (8) cyc();
    check("bp_hold_pulses", 32'(pulse_cnt), 32'd0);
    check("bp_hold_state", 32'(state), 32'd3);
    runReq = 1'b0;
    cyc();
    check("bp_to_halt", 32'(state), 32'd0);
    runReq = 1'b1;
    wait_pulse(20, n);
    check("bp_resume_seen", 32'(n > 0), 32'd1);
    check("bp_resume_pc", last_pc, 32'h0000_000C);
    wait_pulse(20, n);
    check("bp_continue_pc", last_pc, 32'h0000_0010);
    check("bp_continue_state", 32'(state), 32'd1);
    $display("breakpoint resume: last_pc=0x%0h state=%0d", last_pc, state);
`else
    repeat (20) cyc();
    $display("breakpoint disabled: pulses=%0d pc=0x%0h saw_break=%0d",
             pulse_cnt, pc, saw_break);
    check("nobp_pulses", 32'(pulse_cnt), 32'd5);
    check("nobp_pc", pc, 32'h0000_0014);
    check("nobp_no_break", 32'(saw_break), 32'd0);
    check("nobp_state", 32'(state), 32'd1);
`endif
    runReq   = 1'b0;
    bpEnable = 1'b0;

    // 16-bit count wrap on the tick-every-cycle instance.
    w_runReq = 1'b1;
    @(posedge clkIn);
    #1;
    w_rst_n = 1'b1;
    begin
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < 70000 && !reached; i++) begin
        @(posedge clkIn);
        #1;
        if (w_count == 16'hFFFF) reached = 1'b1;
      end
      check("wrap_reached_ffff", 32'(reached), 32'd1);
    end
    @(posedge clkIn);
    #1;
    $display("wrap: count=%0d cpuEn=%0d state=%0d", w_count, w_cpuEn, w_state);
    check("wrap_count", 32'(w_count), 32'd0);
    check("wrap_cpuEn", 32'(w_cpuEn), 32'd1);
    check("wrap_state", 32'(w_state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
